// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with architectural HI/LO registers.
//
// Multiplies (MULT/MULTU) finish MUL_LAT cycles after acceptance. Divides
// (DIV/DIVU) run a radix-2 restoring iteration over operand magnitudes for
// WIDTH cycles; sign correction is folded into the last iteration edge and
// the FIX state is the completion cycle in which done is high.
//
// Optional feature macro: MULDIV_MADD_EN
//   defined     -> MADD/MADDU/MSUB/MSUBU accumulate the product into {hi,lo}
//   not defined -> accumulate logic is absent and a start with op[2]=1 is
//                  ignored entirely (no busy, no done, HI/LO untouched).
//
// Handshake: start is taken at a rising clk edge only while busy=0. done is a
// one-cycle pulse raised in the completion cycle; busy is still 1 during that
// cycle and drops on the next one, so a new start may be presented in the
// cycle where busy reads 0. hi_we/lo_we are honoured only while busy=0.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [1:0]       state_dbg
);

    // Counter wide enough to count the WIDTH divide iterations.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
    // With a single-cycle multiply the result is written at the accept edge,
    // so the multiplier must see the live inputs instead of the latches.
    localparam bit MUL_DIRECT = (MUL_LAT == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;

    // Latched multiply operands.
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mul_uns_q;

    // Divide datapath: partial remainder, shifting dividend/quotient,
    // divisor magnitude and the result sign flags.
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_q;
    logic               neg_r;

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Start decode
    // ------------------------------------------------------------------
    logic op_ok;
    logic accept;
    logic is_div_op;

`ifdef MULDIV_MADD_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op[2];
`endif

    assign accept    = start & ~busy & op_ok;
    assign is_div_op = (op[2:1] == 2'b01);

    // ------------------------------------------------------------------
    // Multiplier: both operands extended to 2*WIDTH so one unsigned
    // multiply produces the correct low 2*WIDTH bits for either signedness.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   m_a;
    logic [WIDTH-1:0]   m_b;
    logic               m_uns;
    logic [2*WIDTH-1:0] m_ext_a;
    logic [2*WIDTH-1:0] m_ext_b;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mul_res;

    assign m_a   = MUL_DIRECT ? a     : a_q;
    assign m_b   = MUL_DIRECT ? b     : b_q;
    assign m_uns = MUL_DIRECT ? op[0] : mul_uns_q;

    assign m_ext_a = m_uns ? {{WIDTH{1'b0}}, m_a} : {{WIDTH{m_a[WIDTH-1]}}, m_a};
    assign m_ext_b = m_uns ? {{WIDTH{1'b0}}, m_b} : {{WIDTH{m_b[WIDTH-1]}}, m_b};
    assign product = m_ext_a * m_ext_b;

`ifdef MULDIV_MADD_EN
    logic               acc_q;
    logic               sub_q;
    logic               m_acc;
    logic               m_sub;
    logic [2*WIDTH-1:0] acc_base;

    assign m_acc = MUL_DIRECT ? op[2] : acc_q;
    assign m_sub = MUL_DIRECT ? op[1] : sub_q;
    // A same-cycle MTHI/MTLO must be the accumulate base when the result
    // is written at the accept edge; otherwise the write already landed.
    assign acc_base = MUL_DIRECT ? {(hi_we ? wdata : hi), (lo_we ? wdata : lo)}
                                 : {hi, lo};

    // Select plain product, accumulate or subtract (wraps modulo 2^(2*WIDTH)).
    always_comb begin
        mul_res = product;
        if (m_acc) begin
            mul_res = m_sub ? (acc_base - product) : (acc_base + product);
        end
    end
`else
    assign mul_res = product;
`endif

    // ------------------------------------------------------------------
    // Divider step: shift one dividend bit into the remainder and keep the
    // trial subtraction when it does not go negative.
    // ------------------------------------------------------------------
    logic             div_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    assign div_signed = ~op[0];
    // Negating the most negative value yields 2^(WIDTH-1) as an unsigned
    // magnitude, which is exactly what the overflow case needs.
    assign a_mag = (div_signed & a[WIDTH-1]) ? -a : a;
    assign b_mag = (div_signed & b[WIDTH-1]) ? -b : b;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign take     = ~trial[WIDTH];
    assign step_rem = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], take};

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign fix_q = neg_q ? -step_quo : step_quo;
    assign fix_r = neg_r ? -step_rem : step_rem;

    // ------------------------------------------------------------------
    // Control FSM, HI/LO registers and datapath registers.
    // ------------------------------------------------------------------
    // Single sequential process: reset beats start and HI/LO writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mul_uns_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q     <= 1'b0;
            sub_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        busy      <= 1'b1;
                        dz        <= 1'b0;
                        a_q       <= a;
                        b_q       <= b;
                        mul_uns_q <= op[0];
`ifdef MULDIV_MADD_EN
                        acc_q     <= op[2];
                        sub_q     <= op[1];
`endif
                        if (is_div_op) begin
                            if (b == '0) begin
                                // Divide by zero completes immediately.
                                state <= S_FIX;
                                done  <= 1'b1;
                                lo    <= '1;
                                hi    <= a;
                                dz    <= 1'b1;
                            end else begin
                                state <= S_DIV;
                                cnt   <= '0;
                                rem_q <= '0;
                                quo_q <= a_mag;
                                dvs_q <= b_mag;
                                neg_q <= div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r <= div_signed & a[WIDTH-1];
                            end
                        end else begin
                            state <= S_MUL;
                            cnt   <= CW'(1);
                            if (MUL_DIRECT) begin
                                done     <= 1'b1;
                                {hi, lo} <= mul_res;
                            end
                        end
                    end
                end

                S_MUL: begin
                    if (done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == MUL_LAST) begin
                        done     <= 1'b1;
                        {hi, lo} <= mul_res;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DIV: begin
                    if (cnt == DIV_LAST) begin
                        // Last quotient bit: correct signs and publish.
                        state <= S_FIX;
                        done  <= 1'b1;
                        hi    <= fix_r;
                        lo    <= fix_q;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                    end
                end

                S_FIX: begin
                    // Completion cycle (done high); return to IDLE next.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
